// File: rtl/pc_fetch_unit.sv
// Sequential fetch front end: PC register, one-outstanding imem request,
// instruction hand-off to decode, redirect handling and misalignment trap.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   redirect_valid/target           branch/jump redirect
//   imem_req_valid/addr/ready       fetch request channel (addr = pc)
//   imem_rsp_valid/data             fetch response channel
//   instr_valid/instr/instr_pc      registered instruction to decode
//   decode_ready                    decode consumes instruction
//   misaligned_fault/fault_addr     sticky trap on misaligned redirect
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        decode_ready,
    output logic        misaligned_fault,
    output logic [31:0] fault_addr
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic        kill, kill_d;
    logic [31:0] instr_d, instr_pc_d, fault_addr_d;
    logic        instr_valid_d, fault_d;
    logic        redir_ok, redir_bad, active;

    assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign active    = (state == REQ) || (state == WAIT) || (state == HOLD);

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;

    always_comb begin
        state_d       = state;
        pc_d          = pc;
        kill_d        = kill;
        instr_d       = instr;
        instr_pc_d    = instr_pc;
        instr_valid_d = instr_valid;
        fault_d       = misaligned_fault;
        fault_addr_d  = fault_addr;

        if (active && redir_bad) begin
            // pc is left untouched so the trap handler sees where we were
            fault_d       = 1'b1;
            fault_addr_d  = redirect_target;
            instr_valid_d = 1'b0;
            state_d       = FAULT;
        end else begin
            unique case (state)
                IDLE: state_d = REQ;
                REQ: begin
                    if (redir_ok) begin
                        pc_d = redirect_target;
                        // old-address request still goes out; drop its reply
                        if (imem_req_ready) begin
                            kill_d  = 1'b1;
                            state_d = WAIT;
                        end
                    end else if (imem_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (redir_ok) begin
                        pc_d = redirect_target;
                        if (imem_rsp_valid) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            kill_d = 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (kill) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            instr_d       = imem_rsp_data;
                            instr_pc_d    = pc;
                            instr_valid_d = 1'b1;
                            pc_d          = pc + 32'd4;
                            state_d       = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redir_ok) begin
                        instr_valid_d = 1'b0;
                        pc_d          = redirect_target;
                        state_d       = REQ;
                    end else if (decode_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = REQ;
                    end
                end
                FAULT: state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc               <= RESET_PC;
            kill             <= 1'b0;
            instr            <= 32'h0;
            instr_pc         <= 32'h0;
            instr_valid      <= 1'b0;
            misaligned_fault <= 1'b0;
            fault_addr       <= 32'h0;
        end else begin
            pc               <= pc_d;
            kill             <= kill_d;
            instr            <= instr_d;
            instr_pc         <= instr_pc_d;
            instr_valid      <= instr_valid_d;
            misaligned_fault <= fault_d;
            fault_addr       <= fault_addr_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: random memory latency, ready,
// decode stalls and redirects, checked against a flag-based fetch model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready = 1'b0;
    logic        misaligned_fault;
    logic [31:0] fault_addr;

    pc_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .decode_ready     (decode_ready),
        .misaligned_fault (misaligned_fault),
        .fault_addr       (fault_addr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // reference model: what the fetch unit owes the outside world
    bit          m_started, m_fault, m_busy, m_stale, m_have;
    logic [31:0] m_pc, m_instr, m_instr_pc, m_fault_addr;

    task automatic model_reset();
        m_started    = 0;
        m_fault      = 0;
        m_busy       = 0;
        m_stale      = 0;
        m_have       = 0;
        m_pc         = RPC;
        m_instr      = 0;
        m_instr_pc   = 0;
        m_fault_addr = 0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        t = redirect_target;
        if (!m_started) begin
            m_started = 1;
        end else if (m_fault) begin
        end else if (redirect_valid && t[1:0] != 2'b00) begin
            m_fault      = 1;
            m_fault_addr = t;
            m_have       = 0;
            m_busy       = 0;
        end else if (redirect_valid) begin
            m_pc = t;
            if (m_have) begin
                m_have = 0;
            end else if (m_busy) begin
                if (imem_rsp_valid) begin
                    m_busy  = 0;
                    m_stale = 0;
                end else begin
                    m_stale = 1;
                end
            end else if (imem_req_ready) begin
                m_busy  = 1;
                m_stale = 1;
            end
        end else if (m_have) begin
            if (decode_ready) m_have = 0;
        end else if (m_busy) begin
            if (imem_rsp_valid) begin
                m_busy = 0;
                if (m_stale) begin
                    m_stale = 0;
                end else begin
                    m_have     = 1;
                    m_instr    = imem_rsp_data;
                    m_instr_pc = m_pc;
                    m_pc       = m_pc + 32'd4;
                end
            end
        end else if (imem_req_ready) begin
            m_busy = 1;
        end
    endtask

    task automatic compare();
        bit exp_rv;
        exp_rv = m_started && !m_fault && !m_busy && !m_have;
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        check("req_addr", imem_req_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_have));
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_instr_pc);
        check("fault", 32'(misaligned_fault), 32'(m_fault));
        check("fault_addr", fault_addr, m_fault_addr);
    endtask

    // memory stub with random response latency
    bit          mem_busy, acc, allow_bad;
    int          mem_wait;
    logic [31:0] mem_addr, acc_addr;

    task automatic mem_reset();
        mem_busy = 0;
        acc      = 0;
        mem_wait = 0;
    endtask

    task automatic mem_step();
        if (imem_rsp_valid) mem_busy = 0;
        if (acc) begin
            mem_busy = 1;
            mem_addr = acc_addr;
            mem_wait = $urandom_range(0, 2);
        end
    endtask

    task automatic drive();
        int r;
        imem_req_ready = ($urandom_range(0, 9) < 6);
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        if (mem_busy && mem_wait == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (mem_busy) mem_wait--;
        end
        decode_ready   = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 7) == 0);
        r = $urandom_range(0, 15);
        if (r == 0) begin
            redirect_target = 32'hFFFF_FFFC;
        end else if (r == 1 && allow_bad) begin
            redirect_target = (32'($urandom_range(0, 255)) << 2) | 32'h2;
        end else begin
            redirect_target = 32'($urandom_range(0, 255)) << 2;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            model_step();
            mem_step();
        end
        #1;
        compare();
        drive();
    endtask

    initial begin
        model_reset();
        mem_reset();
        allow_bad = 0;
        #2 rst_n = 1'b0;
        #1 compare();
        for (int ep = 0; ep < 6; ep++) begin
            allow_bad = (ep >= 3);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            drive();
            for (int i = 0; i < 300; i++) cycle();
            allow_bad = 0;
            if (!m_fault) begin
                for (int i = 0; i < 60 && !m_busy; i++) cycle();
                check("wait_busy", 32'(m_busy), 32'd1);
            end
            // asynchronous reset mid-operation
            rst_n = 1'b0;
            #1;
            model_reset();
            mem_reset();
            compare();
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
